// File: rtl/btb_ctrl_if.sv
// Fetch-side lookup and execute-side training bundle for btb_ctrl.
//   master : the fetch/next-PC/execute side. It drives pc_fetch, the upd_*
//            training signals and btb_clr, and receives the prediction.
//   slave  : the predictor (btb_ctrl). It returns branch_en and pc_target.
interface btb_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] pc_fetch;
  logic             branch_en;
  logic [WIDTH-1:0] pc_target;
  logic             upd_valid;
  logic [WIDTH-1:0] upd_pc;
  logic             upd_taken;
  logic             upd_is_jump;
  logic [WIDTH-1:0] upd_target;
  logic             btb_clr;

  modport master (
    output pc_fetch, upd_valid, upd_pc, upd_taken, upd_is_jump, upd_target, btb_clr,
    input  branch_en, pc_target
  );

  modport slave (
    input  pc_fetch, upd_valid, upd_pc, upd_taken, upd_is_jump, upd_target, btb_clr,
    output branch_en, pc_target
  );
endinterface

// File: rtl/btb_ctrl.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per entry.
// Lookup is combinational from the registered table, so the next-PC mux sees
// the prediction in the same cycle. The table is trained on the clock edge from
// execute-stage resolution.
//
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   bus (btb_ctrl_if.slave) pc_fetch in; branch_en/pc_target out;
//                          upd_valid/upd_pc/upd_taken/upd_is_jump/upd_target
//                          and btb_clr in
//   stat_upd_cnt, stat_mispred_cnt (only when BTB_STATS_EN is defined)
//                          free-running update and misprediction counters
//
// Optional feature macro: BTB_STATS_EN.
//
// Entry counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
module btb_ctrl #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  btb_ctrl_if.slave     bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]   stat_upd_cnt,
  output logic [31:0]   stat_mispred_cnt
`endif
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = WIDTH - IDX - 2;

  logic             valid_q [ENTRIES];
  logic [TAGW-1:0]  tag_q   [ENTRIES];
  logic [WIDTH-1:0] tgt_q   [ENTRIES];
  logic             jmp_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  // Lookup
  logic [IDX-1:0]   f_idx;
  logic [TAGW-1:0]  f_tag;
  logic             f_hit;

  assign f_idx = bus.pc_fetch[IDX+1:2];
  assign f_tag = bus.pc_fetch[WIDTH-1:IDX+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign bus.branch_en = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
  assign bus.pc_target = bus.branch_en ? tgt_q[f_idx] : '0;

  // Training: only the entry selected by upd_pc is touched
  logic [IDX-1:0]   u_idx;
  logic [TAGW-1:0]  u_tag;
  logic             u_hit;
  logic             u_we;
  logic [TAGW-1:0]  tag_d;
  logic [WIDTH-1:0] tgt_d;
  logic             jmp_d;
  logic [1:0]       ctr_d;

  assign u_idx = bus.upd_pc[IDX+1:2];
  assign u_tag = bus.upd_pc[WIDTH-1:IDX+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // A miss that resolved not-taken is never allocated.
  assign u_we  = bus.upd_valid && !bus.btb_clr && (u_hit || bus.upd_taken);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_fetch[1:0], bus.upd_pc[1:0]};

  always_comb begin
    tag_d = tag_q[u_idx];
    tgt_d = tgt_q[u_idx];
    jmp_d = jmp_q[u_idx];
    ctr_d = ctr_q[u_idx];
    if (!u_hit) begin
      // Allocation overwrites whatever alias occupied the slot.
      tag_d = u_tag;
      tgt_d = bus.upd_target;
      jmp_d = bus.upd_is_jump;
      ctr_d = bus.upd_is_jump ? 2'b11 : 2'b10;
    end else if (bus.upd_is_jump) begin
      tgt_d = bus.upd_target;
      jmp_d = 1'b1;
      ctr_d = 2'b11;
    end else begin
      jmp_d = 1'b0;
      if (bus.upd_taken) begin
        tgt_d = bus.upd_target;
        if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'd1;
      end else begin
        if (ctr_q[u_idx] != 2'b00) ctr_d = ctr_q[u_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        jmp_q[i]   <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (bus.btb_clr) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (u_we) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= tag_d;
      tgt_q[u_idx]   <= tgt_d;
      jmp_q[u_idx]   <= jmp_d;
      ctr_q[u_idx]   <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_mis_q;
  logic        u_pred_taken;
  logic        u_mispred;

  // Prediction the table would have given for upd_pc at this edge.
  assign u_pred_taken = u_hit && (jmp_q[u_idx] || ctr_q[u_idx][1]);
  assign u_mispred    = (u_pred_taken != bus.upd_taken) ||
                        (u_pred_taken && (tgt_q[u_idx] != bus.upd_target));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else if (bus.upd_valid && !bus.btb_clr) begin
      stat_upd_q <= stat_upd_q + 32'd1;
      if (u_mispred) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_upd_cnt     = stat_upd_q;
  assign stat_mispred_cnt = stat_mis_q;
`endif

endmodule
